// File: rtl/text_console_writer_if.sv
// Byte-stream input and text-memory write/read port of the console writer.
// slave: the writer itself; master: the byte source plus text memory side.
interface text_console_writer_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [9:0] char_addr;
  logic [7:0] char_wdata;
  logic       char_we;
  logic [7:0] char_rdata;

  modport slave (
    input  in_valid, in_char, char_rdata,
    output in_ready, char_addr, char_wdata, char_we
  );

  modport master (
    output in_valid, in_char, char_rdata,
    input  in_ready, char_addr, char_wdata, char_we
  );
endinterface

// File: rtl/text_console_writer.sv
// Terminal-style writer for the COLS x ROWS text memory: cursor tracking,
// line wrap, LF/CR/BS/FF handling and a copy-up hardware scroll.
//
// state   | meaning
// IDLE    | accepting bytes, one per cycle
// SCRL_RD | scroll: launch read of cell idx+COLS
// SCRL_WR | scroll: write the fetched byte to cell idx
// CLR_ROW | blank the bottom row after a scroll
// CLR_ALL | blank the whole screen after form-feed
//
// char_rdata is sampled on the edge following the one that launched the read
// address, so each scrolled cell costs exactly one read and one write cycle.
module text_console_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  text_console_writer_if.slave        bus,
  output logic                        busy,
  output logic [5:0]                  cursor_x,
  output logic [4:0]                  cursor_y
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SCRL_RD = 3'd1;
  localparam logic [2:0] SCRL_WR = 3'd2;
  localparam logic [2:0] CLR_ROW = 3'd3;
  localparam logic [2:0] CLR_ALL = 3'd4;

  localparam logic [5:0] LAST_COL      = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW      = 5'(ROWS - 1);
  localparam logic [9:0] COLS_W        = 10'(COLS);
  localparam logic [9:0] SCRL_LAST     = 10'((ROWS - 1) * COLS - 1);
  localparam logic [9:0] BOT_ROW_BASE  = 10'((ROWS - 1) * COLS);
  localparam logic [9:0] CELL_LAST     = 10'(COLS * ROWS - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [9:0] idx_q, idx_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;

  logic [9:0] cur_addr;
  logic       is_print;

  assign cur_addr = 10'(x_q) + 10'(y_q) * COLS_W;
  assign is_print = (bus.in_char >= 8'h20) && (bus.in_char != 8'h7F);

  assign bus.in_ready   = (state_q == IDLE) && !rst;
  assign bus.char_addr  = addr_q;
  assign bus.char_wdata = wdata_q;
  assign bus.char_we    = we_q;
  assign busy           = (state_q != IDLE);
  assign cursor_x       = x_q;
  assign cursor_y       = y_q;

  // Next-state: byte decode in IDLE, address sequencing for scroll and clears.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_print) begin
            we_d    = 1'b1;
            addr_d  = cur_addr;
            wdata_d = bus.in_char;
            if (x_q == LAST_COL) begin
              x_d = 6'd0;
              if (y_q == LAST_ROW) begin
                state_d = SCRL_RD;
                idx_d   = 10'd0;
              end else begin
                y_d = y_q + 5'd1;
              end
            end else begin
              x_d = x_q + 6'd1;
            end
          end else begin
            case (bus.in_char)
              8'h0A: begin
                x_d = 6'd0;
                if (y_q == LAST_ROW) begin
                  state_d = SCRL_RD;
                  idx_d   = 10'd0;
                end else begin
                  y_d = y_q + 5'd1;
                end
              end
              8'h0D: x_d = 6'd0;
              8'h08: begin
                // The previous cell is always one below in linear address order.
                if ((x_q != 6'd0) || (y_q != 5'd0)) begin
                  we_d    = 1'b1;
                  wdata_d = 8'h00;
                  addr_d  = cur_addr - 10'd1;
                  if (x_q == 6'd0) begin
                    x_d = LAST_COL;
                    y_d = y_q - 5'd1;
                  end else begin
                    x_d = x_q - 6'd1;
                  end
                end
              end
              8'h0C: begin
                x_d     = 6'd0;
                y_d     = 5'd0;
                idx_d   = 10'd0;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      SCRL_RD: begin
        addr_d  = idx_q + COLS_W;
        state_d = SCRL_WR;
      end
      SCRL_WR: begin
        addr_d  = idx_q;
        we_d    = 1'b1;
        wdata_d = bus.char_rdata;
        if (idx_q == SCRL_LAST) begin
          idx_d   = BOT_ROW_BASE;
          state_d = CLR_ROW;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = SCRL_RD;
        end
      end
      CLR_ROW, CLR_ALL: begin
        addr_d  = idx_q;
        we_d    = 1'b1;
        wdata_d = 8'h00;
        if (idx_q == CELL_LAST) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and registered memory port; reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 6'd0;
      y_q     <= 5'd0;
      idx_q   <= 10'd0;
      addr_q  <= 10'd0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

endmodule
